// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant, then one access routed
// to internal RAM (synchronous read) or SFR space (combinational read).
module dmem_arbiter #(
    parameter logic [7:0] SFR_BASE = 8'h80
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_we0,
    input  logic       i_we1,
    input  logic       i_ind0,
    input  logic       i_ind1,
    input  logic [7:0] i_addr0,
    input  logic [7:0] i_addr1,
    input  logic [7:0] i_wdata0,
    input  logic [7:0] i_wdata1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_done0,
    output logic       o_done1,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    output logic [7:0] o_ram_addr,
    output logic       o_ram_we,
    output logic [7:0] o_ram_wdata,
    input  logic [7:0] i_ram_rdata,
    output logic [7:0] o_sfr_addr,
    output logic       o_sfr_we,
    output logic [7:0] o_sfr_wdata,
    input  logic [7:0] i_sfr_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RAM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       gnt0;
    logic       gnt1;
    logic       rr_prio;     // requester that wins the next contested grant
    logic       lat_id;
    logic       lat_we;
    logic       lat_ind;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;
    logic       lat_sfr;
    logic [7:0] rdata_q;

    assign lat_sfr = !lat_ind && (lat_addr >= SFR_BASE);

    // Grants are suppressed while reset is held so nothing is offered before
    // the first rising edge with reset released.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && i_rst_n) begin
            if (i_req0 && i_req1) begin
                gnt0 = !rr_prio;
                gnt1 = rr_prio;
            end else begin
                gnt0 = i_req0;
                gnt1 = i_req1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_we || lat_sfr) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = RAM_WAIT;
                end
            end
            RAM_WAIT: state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_prio   <= 1'b0;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_ind   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                rr_prio   <= gnt0;
                lat_id    <= gnt1;
                lat_we    <= gnt1 ? i_we1    : i_we0;
                lat_ind   <= gnt1 ? i_ind1   : i_ind0;
                lat_addr  <= gnt1 ? i_addr1  : i_addr0;
                lat_wdata <= gnt1 ? i_wdata1 : i_wdata0;
            end
            if (state == ACCESS && !lat_we && lat_sfr) begin
                rdata_q <= i_sfr_rdata;
            end
            // RAM_WAIT is only entered for a RAM read.
            if (state == RAM_WAIT) begin
                rdata_q <= i_ram_rdata;
            end
        end
    end

    always_comb begin
        o_gnt0      = gnt0;
        o_gnt1      = gnt1;
        o_done0     = 1'b0;
        o_done1     = 1'b0;
        o_busy      = (state != IDLE);
        o_rdata     = rdata_q;
        o_ram_addr  = '0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;
        o_sfr_addr  = '0;
        o_sfr_we    = 1'b0;
        o_sfr_wdata = '0;
        case (state)
            ACCESS: begin
                if (lat_sfr) begin
                    o_sfr_addr  = lat_addr;
                    o_sfr_we    = lat_we;
                    o_sfr_wdata = lat_we ? lat_wdata : '0;
                end else begin
                    o_ram_addr  = lat_addr;
                    o_ram_we    = lat_we;
                    o_ram_wdata = lat_we ? lat_wdata : '0;
                end
            end
            RAM_WAIT: begin
                o_ram_addr = lat_addr;
            end
            RESP: begin
                o_done0 = !lat_id;
                o_done1 = lat_id;
            end
            default: ;
        endcase
    end

    a_one_strobe: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_ram_we && o_sfr_we));
    a_one_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_gnt0 && o_gnt1));
    a_one_done: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_done0 && o_done1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous RAM model and a
// small address-decoded SFR read mux.
module tb_dmem_arbiter;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_req0, i_req1;
    logic       i_we0, i_we1;
    logic       i_ind0, i_ind1;
    logic [7:0] i_addr0, i_addr1;
    logic [7:0] i_wdata0, i_wdata1;
    logic       o_gnt0, o_gnt1;
    logic       o_done0, o_done1;
    logic [7:0] o_rdata;
    logic       o_busy;
    logic [7:0] o_ram_addr;
    logic       o_ram_we;
    logic [7:0] o_ram_wdata;
    logic [7:0] i_ram_rdata;
    logic [7:0] o_sfr_addr;
    logic       o_sfr_we;
    logic [7:0] o_sfr_wdata;
    logic [7:0] i_sfr_rdata;

    logic [7:0] mem [0:255];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;
    logic       sfr_we_seen;

    int unsigned n_chk;
    int unsigned n_pass;

    dmem_arbiter #(.SFR_BASE(8'h80)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req0      (i_req0),
        .i_req1      (i_req1),
        .i_we0       (i_we0),
        .i_we1       (i_we1),
        .i_ind0      (i_ind0),
        .i_ind1      (i_ind1),
        .i_addr0     (i_addr0),
        .i_addr1     (i_addr1),
        .i_wdata0    (i_wdata0),
        .i_wdata1    (i_wdata1),
        .o_gnt0      (o_gnt0),
        .o_gnt1      (o_gnt1),
        .o_done0     (o_done0),
        .o_done1     (o_done1),
        .o_rdata     (o_rdata),
        .o_busy      (o_busy),
        .o_ram_addr  (o_ram_addr),
        .o_ram_we    (o_ram_we),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata),
        .o_sfr_addr  (o_sfr_addr),
        .o_sfr_we    (o_sfr_we),
        .o_sfr_wdata (o_sfr_wdata),
        .i_sfr_rdata (i_sfr_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
        i_ram_rdata <= mem[o_ram_addr];
    end

    assign i_sfr_rdata = (o_sfr_addr == 8'hE0) ? 8'h5C :
                         (o_sfr_addr == 8'h90) ? 8'h11 : 8'h00;

    always @(negedge i_clk) if (o_sfr_we) sfr_we_seen = 1'b1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic clear_reqs;
        i_req0 = 0; i_we0 = 0; i_ind0 = 0; i_addr0 = '0; i_wdata0 = '0;
        i_req1 = 0; i_we1 = 0; i_ind1 = 0; i_addr1 = '0; i_wdata1 = '0;
    endtask

    task automatic do_reset;
        clear_reqs();
        i_rst_n = 0;
        tick();
        tick();
        i_rst_n = 1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        sfr_we_seen = 0;
        do_reset();
        #1;
        chk("rst_busy", {7'd0, o_busy}, 8'h00);
        chk("rst_rdata", o_rdata, 8'h00);
        chk("rst_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h00);
        chk("rst_ramaddr", o_ram_addr, 8'h00);

        // Core RAM write 0x30 <= A5
        tick();
        sfr_we_seen = 0;
        i_req0 = 1; i_we0 = 1; i_addr0 = 8'h30; i_wdata0 = 8'hA5;
        #1;
        chk("w_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h01);
        tick();
        i_req0 = 0;
        #1;
        chk("w_ramwe", {7'd0, o_ram_we}, 8'h01);
        chk("w_ramaddr", o_ram_addr, 8'h30);
        chk("w_ramwdata", o_ram_wdata, 8'hA5);
        chk("w_sfraddr", o_sfr_addr, 8'h00);
        chk("w_busy", {7'd0, o_busy}, 8'h01);
        tick();
        #1;
        chk("w_done", {6'd0, o_done1, o_done0}, 8'h01);
        chk("w_rdata_hold", o_rdata, 8'h00);
        tick();
        #1;
        chk("w_idle", {5'd0, o_busy, o_done1, o_done0}, 8'h00);
        chk("w_sfrwe_never", {7'd0, sfr_we_seen}, 8'h00);
        chk("w_mem", mem[8'h30], 8'hA5);

        // Core SFR read 0xE0
        i_req0 = 1; i_we0 = 0; i_addr0 = 8'hE0;
        #1;
        chk("sr_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h01);
        tick();
        i_req0 = 0;
        #1;
        chk("sr_sfraddr", o_sfr_addr, 8'hE0);
        chk("sr_ramaddr", o_ram_addr, 8'h00);
        chk("sr_sfrwe", {7'd0, o_sfr_we}, 8'h00);
        tick();
        #1;
        chk("sr_done", {6'd0, o_done1, o_done0}, 8'h01);
        chk("sr_rdata", o_rdata, 8'h5C);
        tick();
        #1;
        chk("sr_rdata_keep", o_rdata, 8'h5C);

        // Indirect read of 0xE0 goes to RAM
        preload(8'hE0, 8'h77);
        i_req0 = 1; i_ind0 = 1; i_addr0 = 8'hE0;
        #1;
        chk("ir_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h01);
        tick();
        clear_reqs();
        #1;
        chk("ir_ramaddr1", o_ram_addr, 8'hE0);
        chk("ir_sfraddr1", o_sfr_addr, 8'h00);
        tick();
        #1;
        chk("ir_ramaddr2", o_ram_addr, 8'hE0);
        chk("ir_nodone2", {6'd0, o_done1, o_done0}, 8'h00);
        chk("ir_sfraddr2", o_sfr_addr, 8'h00);
        tick();
        #1;
        chk("ir_done", {6'd0, o_done1, o_done0}, 8'h01);
        chk("ir_rdata", o_rdata, 8'h77);
        tick();

        // Decode boundary: 0x7F direct is RAM, 0x80 direct is SFR
        preload(8'h7F, 8'h6B);
        i_req0 = 1; i_addr0 = 8'h7F;
        #1;
        tick();
        i_req0 = 0;
        #1;
        chk("b7f_ramaddr", o_ram_addr, 8'h7F);
        chk("b7f_sfraddr", o_sfr_addr, 8'h00);
        tick();
        tick();
        #1;
        chk("b7f_rdata", o_rdata, 8'h6B);
        chk("b7f_done", {6'd0, o_done1, o_done0}, 8'h01);
        tick();
        i_req1 = 1; i_we1 = 1; i_addr1 = 8'h80; i_wdata1 = 8'h3E;
        #1;
        chk("b80_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h02);
        tick();
        clear_reqs();
        #1;
        chk("b80_we", {6'd0, o_sfr_we, o_ram_we}, 8'h02);
        chk("b80_sfraddr", o_sfr_addr, 8'h80);
        chk("b80_wdata", o_sfr_wdata, 8'h3E);
        tick();
        #1;
        chk("b80_done", {6'd0, o_done1, o_done0}, 8'h02);
        chk("b80_rdata", o_rdata, 8'h6B);
        tick();

        // Both held from reset: grants alternate 0,1,0,1
        do_reset();
        i_req0 = 1; i_addr0 = 8'hE0;
        i_req1 = 1; i_addr1 = 8'h90;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_gnt%0d", k), {6'd0, o_gnt1, o_gnt0},
                (k % 2 == 0) ? 8'h01 : 8'h02);
            tick();
            #1;
            chk($sformatf("rr_nognt%0d", k), {6'd0, o_gnt1, o_gnt0}, 8'h00);
            tick();
            #1;
            chk($sformatf("rr_done%0d", k), {6'd0, o_done1, o_done0},
                (k % 2 == 0) ? 8'h01 : 8'h02);
            chk($sformatf("rr_rdata%0d", k), o_rdata,
                (k % 2 == 0) ? 8'h5C : 8'h11);
            if (k == 3) clear_reqs();
            tick();
        end

        // Reset during RAM_WAIT abandons the read; held req1 wins afterwards
        i_req0 = 1; i_addr0 = 8'h40;
        #1;
        chk("rw_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h01);
        tick();
        i_req0 = 0;
        i_req1 = 1; i_we1 = 1; i_addr1 = 8'h85; i_wdata1 = 8'hC3;
        #1;
        chk("rw_nognt1", {6'd0, o_gnt1, o_gnt0}, 8'h00);
        tick();
        #1;
        chk("rw_wait_addr", o_ram_addr, 8'h40);
        i_rst_n = 0;
        #1;
        chk("rw_rst_busy", {7'd0, o_busy}, 8'h00);
        chk("rw_rst_done", {6'd0, o_done1, o_done0}, 8'h00);
        chk("rw_rst_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h00);
        chk("rw_rst_ramaddr", o_ram_addr, 8'h00);
        chk("rw_rst_rdata", o_rdata, 8'h00);
        tick();
        #1;
        chk("rw_rst_done2", {6'd0, o_done1, o_done0}, 8'h00);
        i_rst_n = 1;
        #1;
        chk("rw_rel_gnt", {6'd0, o_gnt1, o_gnt0}, 8'h02);
        tick();
        i_req1 = 0;
        #1;
        chk("rw_sfrwe", {6'd0, o_sfr_we, o_ram_we}, 8'h02);
        chk("rw_sfraddr", o_sfr_addr, 8'h85);
        tick();
        #1;
        chk("rw_done1", {6'd0, o_done1, o_done0}, 8'h02);
        tick();
        clear_reqs();

        // req1 arriving during the core access waits for IDLE
        i_req0 = 1; i_we0 = 1; i_addr0 = 8'h50; i_wdata0 = 8'h3C;
        #1;
        chk("lt_gnt0", {6'd0, o_gnt1, o_gnt0}, 8'h01);
        tick();
        i_req0 = 0;
        i_req1 = 1; i_addr1 = 8'h50;
        #1;
        chk("lt_acc_nognt", {6'd0, o_gnt1, o_gnt0}, 8'h00);
        tick();
        #1;
        chk("lt_resp_nognt", {6'd0, o_gnt1, o_gnt0}, 8'h00);
        chk("lt_done0", {6'd0, o_done1, o_done0}, 8'h01);
        tick();
        #1;
        chk("lt_gnt1", {6'd0, o_gnt1, o_gnt0}, 8'h02);
        tick();
        i_req1 = 0;
        #1;
        chk("lt_ramaddr", o_ram_addr, 8'h50);
        tick();
        #1;
        chk("lt_wait_nodone", {6'd0, o_done1, o_done0}, 8'h00);
        tick();
        #1;
        chk("lt_done1", {6'd0, o_done1, o_done0}, 8'h02);
        chk("lt_rdata", o_rdata, 8'h3C);
        tick();
        #1;
        chk("lt_idle", {7'd0, o_busy}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter SFR_BASE, default 8'h80: lowest direct address decoded as SFR space.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req0, i_req1  in  1  access request; requester 0 = core, 1 = interrupt/stack unit.
- i_we0, i_we1  in  1  1 = write, 0 = read.
- i_ind0, i_ind1  in  1  1 = indirect addressing, which always targets RAM.
- i_addr0, i_addr1  in  8  byte address.
- i_wdata0, i_wdata1  in  8  write data.
- o_gnt0, o_gnt1  out  1  request accepted this cycle.
- o_done0, o_done1  out  1  one-cycle completion pulse.
- o_rdata  out  8  read data, valid while an o_doneX of a read is high.
- o_busy  out  1  high in any state except IDLE.
- o_ram_addr  out  8  RAM address.
- o_ram_we  out  1  RAM write strobe.
- o_ram_wdata  out  8  RAM write data.
- i_ram_rdata  in  8  synchronous RAM read data, 1-cycle latency.
- o_sfr_addr  out  8  SFR address, driven to the SFR read mux.
- o_sfr_we  out  1  SFR write strobe.
- o_sfr_wdata  out  8  SFR write data.
- i_sfr_rdata  in  8  SFR mux output, combinational.

Function
REQ-004 The block SHALL implement the FSM states IDLE, ACCESS, RAM_WAIT and RESP.
REQ-005 In IDLE, when any i_reqX is high, the block SHALL assert exactly one o_gntX combinationally in that cycle and SHALL latch that requester's we, ind, addr and wdata at the closing edge; the next state SHALL be ACCESS.
REQ-006 When both requests are high in IDLE, the block SHALL grant round-robin: the requester not granted most recently wins. After reset, requester 0 SHALL win.
REQ-007 When only one request is high, the block SHALL grant it regardless of the round-robin pointer; the pointer SHALL update only on a grant.
REQ-008 The block SHALL assert o_gntX only in IDLE; a request dropped before its grant is withdrawn, with no side effect.
REQ-009 Decode: the block SHALL select SFR when ind==0 and addr >= SFR_BASE; otherwise it SHALL select RAM (full 8-bit address).
REQ-010 In ACCESS, the block SHALL drive the latched address onto the selected port only; the unselected port's address SHALL be held at 0 and its we at 0.
REQ-011 ACCESS write: the block SHALL pulse o_ram_we or o_sfr_we for exactly this one cycle, with wdata driven; the next state SHALL be RESP.
REQ-012 ACCESS SFR read: the block SHALL register i_sfr_rdata into the rdata register at the closing edge; the next state SHALL be RESP.
REQ-013 ACCESS RAM read: the next state SHALL be RAM_WAIT, with o_ram_addr held; in RAM_WAIT the block SHALL register i_ram_rdata at the closing edge; the next state SHALL be RESP.
REQ-014 In RESP, the block SHALL pulse o_doneX for the latched requester for one cycle and hold o_rdata, then return to IDLE.
REQ-015 o_rdata SHALL keep its last read value until the next read completes; writes SHALL not change it.
REQ-016 Latency from the grant cycle T: write done at T+2; SFR read done at T+2; RAM read done at T+3. The next grant SHALL be possible no earlier than T+3 (write/SFR) or T+4 (RAM read).
REQ-017 The block SHALL ignore requests arriving in ACCESS, RAM_WAIT or RESP until IDLE, and they SHALL not be lost if held high.
REQ-018 The block SHALL never assert o_ram_we and o_sfr_we in the same cycle, nor both o_gnt or both o_done.
REQ-019 Address arithmetic SHALL be 8-bit with no wrap handling; the block SHALL only pass addresses through.

Reset
REQ-020 When i_rst_n is low, the block SHALL force IDLE immediately (asynchronously), clear the round-robin pointer (favour requester 0), and clear all outputs and latched registers to 0.
REQ-021 A reset during ACCESS, RAM_WAIT or RESP SHALL abandon the operation: no o_done pulse, and o_ram_we/o_sfr_we drop immediately.
REQ-022 After reset release, the first grant SHALL occur no earlier than the first rising edge with i_rst_n high.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Core write, addr 8'h30, data 8'hA5, ind 0 -> o_gnt0 at T, o_ram_we=1 with addr 8'h30 at T+1, o_done0 at T+2, o_sfr_we never high.
- Core read, addr 8'hE0, i_sfr_rdata=8'h5C -> o_sfr_addr=8'hE0 at T+1, o_done0 with o_rdata=8'h5C at T+2.
- Read, ind 1, addr 8'hE0, RAM holds 8'h77 -> RAM selected, o_done0 with o_rdata=8'h77 at T+3, o_sfr_addr stays 0.
- Both requests held high continuously after reset -> grants alternate 0,1,0,1; each done matches its grant.
- Reset asserted in RAM_WAIT -> o_busy=0 and no o_done; after release, the held i_req1 is granted first if i_req0 is low.
- i_req1 raised while the core access is in ACCESS -> no o_gnt1 until IDLE, then o_gnt1 and o_done1 after the correct latency.
